// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if
//   Bundles the per-frame control inputs and the registered game outputs
//   that pass between the player/frame logic and the Pong sequencer.
//   master : drives frame_tick, start and the paddle buttons; observes outputs
//   slave  : the sequencer; samples the inputs and drives positions/scores/state
//   Signals:
//     frame_tick          one-dclk pulse per frame
//     start               start/restart request
//     l_up, l_dn          left paddle buttons
//     r_up, r_dn          right paddle buttons
//     ball_x, ball_y      ball top-left corner (10-bit)
//     pad_l_y, pad_r_y    paddle top rows (10-bit)
//     score_l, score_r    scores (4-bit)
//     game_over           high while the game is over
//     state               IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       l_up;
  logic       l_dn;
  logic       r_up;
  logic       r_dn;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output frame_tick, start, l_up, l_dn, r_up, r_dn,
    input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_over, state
  );

  modport slave (
    input  frame_tick, start, l_up, l_dn, r_up, r_dn,
    output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Frame-rate game sequencer for Pong. On every dclk edge where frame_tick
//   is high it moves the paddles and the ball, resolves wall and paddle
//   bounces, scores misses and steps the IDLE/SERVE/PLAY/POINT/OVER machine.
//   All outputs come straight from registers, so they are stable between
//   ticks and change one dclk after the tick.
//   Ports:
//     dclk  pixel clock
//     clr   asynchronous active-high reset
//     gb    pong_game_ctrl_if.slave: frame_tick, start, buttons in;
//           ball/paddle positions, scores, game_over, state out
module pong_game_ctrl #(
  parameter logic [9:0] FIELD_L      = 10'd50,
  parameter logic [9:0] FIELD_R      = 10'd590,
  parameter logic [9:0] FIELD_T      = 10'd50,
  parameter logic [9:0] FIELD_B      = 10'd430,
  parameter logic [9:0] BALL         = 10'd8,
  parameter logic [9:0] PAD_W        = 10'd8,
  parameter logic [9:0] PAD_H        = 10'd48,
  parameter logic [9:0] PAD_LX       = 10'd60,
  parameter logic [9:0] PAD_RX       = 10'd572,
  parameter logic [9:0] BALL_SPD     = 10'd2,
  parameter logic [9:0] PAD_SPD      = 10'd4,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [3:0] WIN_SCORE    = 4'd7
) (
  input logic             dclk,
  input logic             clr,
  pong_game_ctrl_if.slave gb
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  // Centre positions derived from the field geometry: (316,236) and 216.
  localparam logic [9:0] CTR_X      = (FIELD_L + FIELD_R - BALL) >> 1;
  localparam logic [9:0] CTR_Y      = (FIELD_T + FIELD_B - BALL) >> 1;
  localparam logic [9:0] PAD_MID    = (FIELD_T + FIELD_B - PAD_H) >> 1;
  localparam logic [9:0] PAD_MAX    = FIELD_B - PAD_H;
  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);

  logic [2:0]       state_reg, state_next;
  logic [9:0]       ball_x_reg, ball_x_next;
  logic [9:0]       ball_y_reg, ball_y_next;
  logic [1:0][9:0]  pad_y_reg, pad_y_next;   // [0]=left, [1]=right
  logic [3:0]       score_l_reg, score_l_next;
  logic [3:0]       score_r_reg, score_r_next;
  logic             dx_reg, dx_next;         // 1 = moving right
  logic             dy_reg, dy_next;         // 1 = moving down
  logic [5:0]       serve_cnt_reg, serve_cnt_next;
  logic             game_over_reg, game_over_next;

  logic [1:0]       pad_up, pad_dn;
  logic [1:0][9:0]  pad_moved;
  logic [1:0]       pad_ovl;

  assign pad_up = {gb.r_up, gb.l_up};
  assign pad_dn = {gb.r_dn, gb.l_dn};

  // Per-paddle clamped step and vertical overlap with the ball. The lower
  // bound is checked before subtracting so the unsigned value never wraps.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pad
      assign pad_moved[gi] =
        (pad_up[gi] && !pad_dn[gi]) ?
          ((pad_y_reg[gi] < FIELD_T + PAD_SPD) ? FIELD_T : pad_y_reg[gi] - PAD_SPD) :
        (pad_dn[gi] && !pad_up[gi]) ?
          ((pad_y_reg[gi] + PAD_SPD > PAD_MAX) ? PAD_MAX : pad_y_reg[gi] + PAD_SPD) :
          pad_y_reg[gi];

      assign pad_ovl[gi] = (ball_y_reg + BALL > pad_y_reg[gi]) &&
                           (ball_y_reg < pad_y_reg[gi] + PAD_H);
    end
  endgenerate

  // Horizontal events. A paddle hit is only taken when the ball is still in
  // front of the paddle face and this frame's step would carry it through.
  logic hit_l, hit_r, miss_l, miss_r, scored;

  assign hit_l  = !dx_reg && (ball_x_reg >= PAD_LX + PAD_W) &&
                  (ball_x_reg - BALL_SPD <= PAD_LX + PAD_W - 10'd1) && pad_ovl[0];
  assign hit_r  = dx_reg && (ball_x_reg + BALL <= PAD_RX) &&
                  (ball_x_reg + BALL + BALL_SPD > PAD_RX) && pad_ovl[1];
  assign miss_l = !dx_reg && (ball_x_reg < FIELD_L + BALL_SPD);
  assign miss_r = dx_reg && (ball_x_reg + BALL + BALL_SPD > FIELD_R);
  assign scored = !hit_l && !hit_r && (miss_l || miss_r);

  always_comb begin
    state_next     = state_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    pad_y_next     = pad_y_reg;
    score_l_next   = score_l_reg;
    score_r_next   = score_r_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    serve_cnt_next = serve_cnt_reg;
    game_over_next = game_over_reg;

    if (gb.frame_tick) begin
      case (state_reg)
        S_IDLE: begin
          if (gb.start) begin
            state_next     = S_SERVE;
            serve_cnt_next = '0;
          end
        end

        S_SERVE: begin
          pad_y_next = pad_moved;
          if (serve_cnt_reg == SERVE_LAST) begin
            state_next = S_PLAY;
          end else begin
            serve_cnt_next = serve_cnt_reg + 6'd1;
          end
        end

        S_PLAY: begin
          pad_y_next = pad_moved;

          if (hit_l) begin
            ball_x_next = PAD_LX + PAD_W;
            dx_next     = 1'b1;
          end else if (hit_r) begin
            ball_x_next = PAD_RX - BALL;
            dx_next     = 1'b0;
          end else if (miss_l) begin
            score_r_next = score_r_reg + 4'd1;
            state_next   = S_POINT;
          end else if (miss_r) begin
            score_l_next = score_l_reg + 4'd1;
            state_next   = S_POINT;
          end else if (dx_reg) begin
            ball_x_next = ball_x_reg + BALL_SPD;
          end else begin
            ball_x_next = ball_x_reg - BALL_SPD;
          end

          // The ball is frozen on the tick a point is scored.
          if (!scored) begin
            if (!dy_reg && (ball_y_reg < FIELD_T + BALL_SPD)) begin
              ball_y_next = FIELD_T;
              dy_next     = 1'b1;
            end else if (dy_reg && (ball_y_reg + BALL + BALL_SPD > FIELD_B)) begin
              ball_y_next = FIELD_B - BALL;
              dy_next     = 1'b0;
            end else if (dy_reg) begin
              ball_y_next = ball_y_reg + BALL_SPD;
            end else begin
              ball_y_next = ball_y_reg - BALL_SPD;
            end
          end
        end

        S_POINT: begin
          if ((score_l_reg == WIN_SCORE) || (score_r_reg == WIN_SCORE)) begin
            state_next     = S_OVER;
            game_over_next = 1'b1;
          end else begin
            // dx still points at the side that just missed, which is the
            // player who conceded, so it is left as is for the next serve.
            state_next     = S_SERVE;
            ball_x_next    = CTR_X;
            ball_y_next    = CTR_Y;
            serve_cnt_next = '0;
          end
        end

        S_OVER: begin
          if (gb.start) begin
            state_next     = S_SERVE;
            score_l_next   = '0;
            score_r_next   = '0;
            ball_x_next    = CTR_X;
            ball_y_next    = CTR_Y;
            pad_y_next     = {PAD_MID, PAD_MID};
            serve_cnt_next = '0;
            game_over_next = 1'b0;
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_reg     <= S_IDLE;
      ball_x_reg    <= CTR_X;
      ball_y_reg    <= CTR_Y;
      pad_y_reg     <= {PAD_MID, PAD_MID};
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      serve_cnt_reg <= '0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      pad_y_reg     <= pad_y_next;
      score_l_reg   <= score_l_next;
      score_r_reg   <= score_r_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      serve_cnt_reg <= serve_cnt_next;
      game_over_reg <= game_over_next;
    end
  end

  assign gb.ball_x    = ball_x_reg;
  assign gb.ball_y    = ball_y_reg;
  assign gb.pad_l_y   = pad_y_reg[0];
  assign gb.pad_r_y   = pad_y_reg[1];
  assign gb.score_l   = score_l_reg;
  assign gb.score_r   = score_r_reg;
  assign gb.game_over = game_over_reg;
  assign gb.state     = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
//   Random-stimulus bench for pong_game_ctrl. A game model written with
//   signed integer velocities and plain clamping predicts every output; the
//   DUT is compared against it on each falling dclk edge.
module tb_pong_game_ctrl;
  logic dclk;
  logic clr;

  pong_game_ctrl_if gb ();

  pong_game_ctrl dut (
    .dclk (dclk),
    .clr  (clr),
    .gb   (gb)
  );

  initial dclk = 1'b0;
  always #20 dclk = ~dclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference game model.
  int m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_vx, m_vy, m_cnt, m_go;

  task automatic model_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_pl = 216; m_pr = 216;
    m_sl = 0; m_sr = 0; m_vx = 2; m_vy = 2; m_cnt = 0; m_go = 0;
  endtask

  function automatic int pad_after(int y, bit up, bit dn);
    int t;
    t = y;
    if (up && !dn) t = y - 4;
    else if (dn && !up) t = y + 4;
    if (t < 50) t = 50;
    if (t > 382) t = 382;
    return t;
  endfunction

  function automatic bit overlap(int by, int py);
    return (by + 8 > py) && (by < py + 48);
  endfunction

  task automatic model_tick(input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
    bit scored;
    int ny, npl, npr;
    scored = 0;
    npl = pad_after(m_pl, lu, ld);
    npr = pad_after(m_pr, ru, rd);
    case (m_st)
      0: if (st) begin m_st = 1; m_cnt = 0; end
      1: begin
        m_pl = npl; m_pr = npr;
        if (m_cnt == 59) m_st = 2;
        else m_cnt++;
      end
      2: begin
        if (m_vx < 0 && m_bx >= 68 && m_bx - 2 < 68 && overlap(m_by, m_pl)) begin
          m_bx = 68; m_vx = 2;
        end else if (m_vx > 0 && m_bx + 8 <= 572 && m_bx + 10 > 572 && overlap(m_by, m_pr)) begin
          m_bx = 564; m_vx = -2;
        end else if (m_vx < 0 && m_bx - 2 < 50) begin
          m_sr++; m_st = 3; scored = 1;
        end else if (m_vx > 0 && m_bx + 10 > 590) begin
          m_sl++; m_st = 3; scored = 1;
        end else begin
          m_bx += m_vx;
        end
        if (!scored) begin
          ny = m_by + m_vy;
          if (ny < 50) begin m_by = 50; m_vy = 2; end
          else if (ny + 8 > 430) begin m_by = 422; m_vy = -2; end
          else m_by = ny;
        end
        m_pl = npl; m_pr = npr;
      end
      3: begin
        if (m_sl == 7 || m_sr == 7) begin
          m_st = 4; m_go = 1;
        end else begin
          m_st = 1; m_bx = 316; m_by = 236; m_cnt = 0;
        end
      end
      4: if (st) begin
        m_st = 1; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
        m_pl = 216; m_pr = 216; m_cnt = 0; m_go = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     32'(gb.state),     32'(m_st));
    check({tag, ".ball_x"},    32'(gb.ball_x),    32'(m_bx));
    check({tag, ".ball_y"},    32'(gb.ball_y),    32'(m_by));
    check({tag, ".pad_l_y"},   32'(gb.pad_l_y),   32'(m_pl));
    check({tag, ".pad_r_y"},   32'(gb.pad_r_y),   32'(m_pr));
    check({tag, ".score_l"},   32'(gb.score_l),   32'(m_sl));
    check({tag, ".score_r"},   32'(gb.score_r),   32'(m_sr));
    check({tag, ".game_over"}, 32'(gb.game_over), 32'(m_go));
  endtask

  // Button policy: a player either tracks the ball or mashes randomly.
  task automatic pick_buttons(input bit track, input int py, output bit up, output bit dn);
    if (track) begin
      up = (py + 24 > m_by + 4 + 2);
      dn = (py + 24 < m_by + 4 - 2);
    end else begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
    end
  endtask

  int  over_seen;
  int  ticks;
  bit  track_l, track_r;

  initial begin
    bit tk, st, lu, ld, ru, rd;
    over_seen = 0;
    ticks = 0;
    track_l = 1'b0;
    track_r = 1'b0;
    clr = 1'b0;
    gb.frame_tick = 1'b0; gb.start = 1'b0;
    gb.l_up = 1'b0; gb.l_dn = 1'b0; gb.r_up = 1'b0; gb.r_dn = 1'b0;
    model_reset();

    #2 clr = 1'b1;
    #3 check_all("reset");
    repeat (2) @(negedge dclk);
    clr = 1'b0;

    for (int n = 0; n < 30000; n++) begin
      @(negedge dclk);
      check_all("tick");
      if (gb.game_over === 1'b1) over_seen = 1;

      if (n % 400 == 0) begin
        track_l = ($urandom_range(0, 99) < 60);
        track_r = ($urandom_range(0, 99) < 60);
      end

      if (n == 16001) begin
        // Asynchronous clear, observed before the next rising edge.
        gb.frame_tick = 1'b0;
        gb.start = 1'b0;
        #5 clr = 1'b1;
        model_reset();
        #1 check_all("clr_async");
        @(negedge dclk);
        clr = 1'b0;
        continue;
      end

      tk = 1'($urandom_range(0, 1));
      if (m_st == 0 || m_st == 4)
        st = ($urandom_range(0, 99) < 15);
      else
        st = 1'($urandom_range(0, 1));
      pick_buttons(track_l, m_pl, lu, ld);
      pick_buttons(track_r, m_pr, ru, rd);

      gb.frame_tick = tk;
      gb.start = st;
      gb.l_up = lu; gb.l_dn = ld; gb.r_up = ru; gb.r_dn = rd;
      if (tk) begin
        ticks++;
        model_tick(st, lu, ld, ru, rd);
      end
    end

    @(negedge dclk);
    gb.frame_tick = 1'b0;
    check_all("final");
    check("over_reached", 32'(over_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
